// File: rtl/bf16_div_seq.sv
// Sequential bfloat16 divider (a / b): restoring mantissa division, one quotient bit per clock.
// Optional macro BF16_DIV_ROUND_NEAREST_EN selects round-to-nearest-even; default truncates.
module bf16_div_seq #(
    parameter int N     = 16,
    parameter int QBITS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         div_by_zero,
    output logic         invalid
);

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t state_reg, state_next;

    logic                    sign_reg;
    logic signed [9:0]       exp_reg;
    logic [7:0]              mb_reg;
    logic [9:0]              rem_reg;
    logic [QBITS-1:0]        q_reg;
    logic [3:0]              cnt_reg;
    logic [N-1:0]            result_reg;
    logic                    overflow_reg;
    logic                    underflow_reg;
    logic                    div_by_zero_reg;
    logic                    invalid_reg;

    // Operand classification, identical for both inputs
    logic [N-1:0] opnd [2];
    logic [1:0]   is_zero;
    logic [1:0]   is_inf;
    logic [1:0]   is_nan;

    assign opnd[0] = a;
    assign opnd[1] = b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cls
            assign is_zero[gi] = (opnd[gi][14:7] == 8'h00);
            assign is_inf[gi]  = (opnd[gi][14:7] == 8'hFF) && (opnd[gi][6:0] == 7'h00);
            assign is_nan[gi]  = (opnd[gi][14:7] == 8'hFF) && (opnd[gi][6:0] != 7'h00);
        end
    endgenerate

    logic              sgn;
    logic              sp_hit;
    logic [N-1:0]      sp_result;
    logic              sp_invalid;
    logic              sp_dbz;
    logic signed [9:0] e_init;

    assign sgn    = a[15] ^ b[15];
    assign e_init = $signed({2'b00, a[14:7]}) - $signed({2'b00, b[14:7]}) + 10'sd127;

    always_comb begin
        sp_hit     = 1'b1;
        sp_result  = 16'h0000;
        sp_invalid = 1'b0;
        sp_dbz     = 1'b0;
        if (is_nan[0] || is_nan[1] || (is_zero[0] && is_zero[1]) || (is_inf[0] && is_inf[1])) begin
            sp_result  = 16'h7FC0;
            sp_invalid = 1'b1;
        end else if (is_inf[0]) begin
            sp_result = {sgn, 8'hFF, 7'h00};
        end else if (is_zero[1]) begin
            sp_result = {sgn, 8'hFF, 7'h00};
            sp_dbz    = 1'b1;
        end else if (is_inf[1] || is_zero[0]) begin
            sp_result = {sgn, 15'h0000};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // One restoring-division step; remainder is stored pre-shifted for the next bit
    logic       rem_ge;
    logic [9:0] rem_sub;

    assign rem_ge  = (rem_reg >= {2'b00, mb_reg});
    assign rem_sub = rem_ge ? (rem_reg - {2'b00, mb_reg}) : rem_reg;

    // Normalisation and rounding of the finished quotient
    logic [7:0]        mant_pre;
    logic [7:0]        mant_fin;
    logic              guard;
    logic              sticky;
    logic signed [9:0] e_norm;
    logic signed [9:0] e_fin;
    logic [N-1:0]      norm_result;
    logic              norm_ovf;
    logic              norm_unf;
    logic              norm_unused;

    always_comb begin
        if (q_reg[9]) begin
            mant_pre = q_reg[9:2];
            guard    = q_reg[1];
            sticky   = q_reg[0] | (rem_reg != 10'd0);
            e_norm   = exp_reg;
        end else begin
            mant_pre = q_reg[8:1];
            guard    = q_reg[0];
            sticky   = (rem_reg != 10'd0);
            e_norm   = exp_reg - 10'sd1;
        end
    end

`ifdef BF16_DIV_ROUND_NEAREST_EN
    logic       round_up;
    logic [8:0] mant_sum;

    assign round_up = guard & (sticky | mant_pre[0]);
    assign mant_sum = {1'b0, mant_pre} + {8'h00, round_up};

    always_comb begin
        if (mant_sum[8]) begin
            mant_fin = 8'h80;
            e_fin    = e_norm + 10'sd1;
        end else begin
            mant_fin = mant_sum[7:0];
            e_fin    = e_norm;
        end
    end
`else
    assign mant_fin = mant_pre;
    assign e_fin    = e_norm;
`endif

    // Hidden bit is always set; guard/sticky only matter when rounding
    assign norm_unused = ^{guard, sticky, mant_fin[7]};

    always_comb begin
        norm_result = {sign_reg, e_fin[7:0], mant_fin[6:0]};
        norm_ovf    = 1'b0;
        norm_unf    = 1'b0;
        if (e_fin >= 10'sd255) begin
            norm_result = {sign_reg, 8'hFF, 7'h00};
            norm_ovf    = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            norm_result = {sign_reg, 15'h0000};
            norm_unf    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = sp_hit ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (cnt_reg == 4'(QBITS - 1)) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_reg        <= 1'b0;
            exp_reg         <= 10'sd0;
            mb_reg          <= 8'h00;
            rem_reg         <= 10'd0;
            q_reg           <= '0;
            cnt_reg         <= 4'd0;
            result_reg      <= '0;
            overflow_reg    <= 1'b0;
            underflow_reg   <= 1'b0;
            div_by_zero_reg <= 1'b0;
            invalid_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg <= sgn;
                        if (sp_hit) begin
                            result_reg      <= sp_result;
                            overflow_reg    <= 1'b0;
                            underflow_reg   <= 1'b0;
                            div_by_zero_reg <= sp_dbz;
                            invalid_reg     <= sp_invalid;
                        end else begin
                            rem_reg <= {3'b001, a[6:0]};
                            mb_reg  <= {1'b1, b[6:0]};
                            exp_reg <= e_init;
                            q_reg   <= '0;
                            cnt_reg <= 4'd0;
                        end
                    end
                end
                DIVIDE: begin
                    rem_reg <= rem_sub << 1;
                    q_reg   <= {q_reg[QBITS-2:0], rem_ge};
                    cnt_reg <= cnt_reg + 4'd1;
                end
                NORM: begin
                    result_reg      <= norm_result;
                    overflow_reg    <= norm_ovf;
                    underflow_reg   <= norm_unf;
                    div_by_zero_reg <= 1'b0;
                    invalid_reg     <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (state_reg == IDLE) & ~rst;
    assign out_valid   = (state_reg == DONE);
    assign result      = result_reg;
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;
    assign div_by_zero = div_by_zero_reg;
    assign invalid     = invalid_reg;

endmodule

// File: tb/tb_bf16_div_seq.sv
// Directed bench for bf16_div_seq: expected results queued at drive time, checked on completion.
module tb_bf16_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        invalid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];

`ifdef BF16_DIV_ROUND_NEAREST_EN
    localparam logic [15:0] ONE_THIRD   = 16'h3EAB;
    localparam logic [15:0] TWO_THIRDS  = 16'h3F2B;
`else
    localparam logic [15:0] ONE_THIRD   = 16'h3EAA;
    localparam logic [15:0] TWO_THIRDS  = 16'h3F2A;
`endif

    always #5 clk = ~clk;

    bf16_div_seq #(.N(16), .QBITS(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    function automatic logic [3:0] flags_now();
        return {overflow, underflow, div_by_zero, invalid};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; leaves the bench at a falling edge with the DUT idle.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_in,
                         input logic [15:0] eres, input logic [3:0] eflags,
                         input int elat, input int hold, input string tag);
        exp_t e;
        exp_t got;
        int   lat;
        bit   seen;
        logic [15:0] held_res;
        logic [3:0]  held_flags;
        e.res = eres; e.flags = eflags; e.lat = elat; e.tag = tag;
        sb.push_back(e);
        a         = ta;
        b         = tb_in;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        got = sb.pop_front();
        check({got.tag, "_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            check({got.tag, "_result"}, {16'b0, result}, {16'b0, got.res});
            check({got.tag, "_flags"}, {28'b0, flags_now()}, {28'b0, got.flags});
            check({got.tag, "_latency"}, lat, got.lat);
            held_res   = result;
            held_flags = flags_now();
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({got.tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
                check({got.tag, "_hold_result"}, {16'b0, result}, {16'b0, held_res});
                check({got.tag, "_hold_flags"}, {28'b0, flags_now()}, {28'b0, held_flags});
                check({got.tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check({got.tag, "_drain_valid"}, {31'b0, out_valid}, 32'd0);
            check({got.tag, "_drain_in_ready"}, {31'b0, in_ready}, 32'd1);
            $display("op %s: a=%h b=%h result=%h flags=%b latency=%0d", got.tag, ta, tb_in,
                     result, flags_now(), lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 16'h0000;
        b         = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", {16'b0, result}, 32'h0);
        check("rst_flags", {28'b0, flags_now()}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);

        do_op(16'h3F80, 16'h3F80, 16'h3F80, 4'b0000, 12, 0, "one_div_one");
        do_op(16'h40C0, 16'h4000, 16'h4040, 4'b0000, 12, 0, "six_div_two");
        do_op(16'h3F80, 16'h4040, ONE_THIRD, 4'b0000, 12, 0, "one_div_three");
        do_op(16'h3F80, 16'h3FC0, TWO_THIRDS, 4'b0000, 12, 0, "one_div_1p5");
        do_op(16'hC0C0, 16'h4000, 16'hC040, 4'b0000, 12, 0, "neg_six_div_two");
        do_op(16'h3F80, 16'h0000, 16'h7F80, 4'b0010, 1, 0, "div_by_zero");
        do_op(16'h0000, 16'h0000, 16'h7FC0, 4'b0001, 1, 0, "zero_div_zero");
        do_op(16'hBF80, 16'h7F80, 16'h8000, 4'b0000, 1, 0, "fin_div_inf");
        do_op(16'h7FC1, 16'h3F80, 16'h7FC0, 4'b0001, 1, 0, "nan_in");
        do_op(16'h7F80, 16'hC000, 16'hFF80, 4'b0000, 1, 0, "inf_div_fin");
        do_op(16'h7F00, 16'h3E80, 16'h7F80, 4'b1000, 12, 0, "overflow");
        do_op(16'h0080, 16'h4000, 16'h0000, 4'b0100, 12, 0, "underflow");
        do_op(16'h40C0, 16'h4000, 16'h4040, 4'b0000, 12, 5, "backpressure");

        // Abort an operation partway through the divide phase
        a        = 16'h40C0;
        b        = 16'h3F80;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_result", {16'b0, result}, 32'h0);
        check("abort_flags", {28'b0, flags_now()}, 32'h0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd0);
        $display("op abort: reset asserted during divide, result=%h", result);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_idle", {31'b0, out_valid}, 32'd0);

        do_op(16'h40C0, 16'h4000, 16'h4040, 4'b0000, 12, 0, "after_abort");

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
